// File: rtl/wallace_pkg.sv
// rtl/wallace_pkg.sv - shared constants and types for the Wallace multiplier MAC path
// Product width matches the 4x4 multiplier output; the MAC stage FSM states live here too.
package wallace_pkg;

   localparam int PROD_W = 8;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } mac_state_t;

endpackage

// File: rtl/wallace_mac_accum.sv
// rtl/wallace_mac_accum.sv - sums groups of N_TERMS products and hands each sum downstream
// Input stalls while a finished sum waits; handshake outputs decode registered state only.
module wallace_mac_accum #(
   parameter int PROD_W  = wallace_pkg::PROD_W,
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 10,
   localparam int CNT_W  = $clog2(N_TERMS) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [CNT_W-1:0]  term_cnt
);

   import wallace_pkg::*;

   if (N_TERMS < 2) begin : g_bad_terms
      $error("wallace_mac_accum: N_TERMS must be at least 2");
   end
   if (ACC_W < PROD_W + $clog2(N_TERMS)) begin : g_bad_width
      $error("wallace_mac_accum: ACC_W too narrow for N_TERMS products");
   end

   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

   mac_state_t       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] acc_out_q, acc_out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] sum;

   assign sum = acc_q + ACC_W'(prod_in);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      acc_out_d = acc_out_q;
      cnt_d     = cnt_q;
      if (clear) begin
         // A pending result and any product offered this cycle are both dropped.
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (prod_valid) begin
                  if (cnt_q == LAST_TERM) begin
                     acc_out_d = sum;
                     acc_d     = '0;
                     cnt_d     = '0;
                     state_d   = HOLD;
                  end else begin
                     acc_d = sum;
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (acc_ready) begin
                  state_d = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         acc_out_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         acc_out_q <= acc_out_d;
         cnt_q     <= cnt_d;
      end
   end

   assign prod_ready = (state_q == ACCUM);
   assign acc_valid  = (state_q == HOLD);
   assign acc_out    = acc_out_q;
   assign term_cnt   = cnt_q;

endmodule

// File: tb/tb_wallace_mac_accum.sv
// tb/tb_wallace_mac_accum.sv - directed vector bench for wallace_mac_accum
// Cycle table for streaming groups, hand-written sequences for stall, clear and reset.
module tb_wallace_mac_accum;

   localparam int PROD_W  = 8;
   localparam int N_TERMS = 4;
   localparam int ACC_W   = 10;
   localparam int CNT_W   = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear;
   logic [PROD_W-1:0] prod_in;
   logic              prod_valid;
   logic              prod_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              acc_valid;
   logic              acc_ready;
   logic [CNT_W-1:0]  term_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wallace_mac_accum #(
      .PROD_W (PROD_W),
      .N_TERMS(N_TERMS),
      .ACC_W  (ACC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .prod_in   (prod_in),
      .prod_valid(prod_valid),
      .prod_ready(prod_ready),
      .acc_out   (acc_out),
      .acc_valid (acc_valid),
      .acc_ready (acc_ready),
      .term_cnt  (term_cnt)
   );

   typedef struct {
      logic [7:0] prod;
      logic       valid;
      logic       ready;
      logic [2:0] cnt;
      logic       pr;
      logic       av;
      logic [9:0] out;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [7:0] p, input logic v, input logic r,
                               input logic [2:0] c, input logic pr, input logic av,
                               input logic [9:0] o);
      vec_t x;
      x.prod = p; x.valid = v; x.ready = r; x.cnt = c; x.pr = pr; x.av = av; x.out = o;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [7:0] p);
      prod_in    = p;
      prod_valid = 1'b1;
      step();
      prod_valid = 1'b0;
      prod_in    = 'x;
   endtask

   task automatic chk_all(input string name, input logic [2:0] c, input logic pr,
                          input logic av, input logic [9:0] o);
      chk({name, " term_cnt"}, 32'(term_cnt), 32'(c));
      chk({name, " prod_ready"}, 32'(prod_ready), 32'(pr));
      chk({name, " acc_valid"}, 32'(acc_valid), 32'(av));
      chk({name, " acc_out"}, 32'(acc_out), 32'(o));
   endtask

   initial begin
      rst_n      = 1'b0;
      clear      = 1'b0;
      prod_in    = '0;
      prod_valid = 1'b0;
      acc_ready  = 1'b1;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk_all("reset", 3'd0, 1'b1, 1'b0, 10'd0);

      // Back-to-back 225 x4 then gapped 1,_,2,_,_,3,4; expected state after each edge
      vecs.push_back(mk(8'd225, 1, 1, 3'd1, 1, 0, 10'd0));
      vecs.push_back(mk(8'd225, 1, 1, 3'd2, 1, 0, 10'd0));
      vecs.push_back(mk(8'd225, 1, 1, 3'd3, 1, 0, 10'd0));
      vecs.push_back(mk(8'd225, 1, 1, 3'd0, 0, 1, 10'd900));
      vecs.push_back(mk(8'd0,   0, 1, 3'd0, 1, 0, 10'd900));
      vecs.push_back(mk(8'd1,   1, 1, 3'd1, 1, 0, 10'd900));
      vecs.push_back(mk(8'hff,  0, 1, 3'd1, 1, 0, 10'd900));
      vecs.push_back(mk(8'd2,   1, 1, 3'd2, 1, 0, 10'd900));
      vecs.push_back(mk(8'hff,  0, 1, 3'd2, 1, 0, 10'd900));
      vecs.push_back(mk(8'hff,  0, 1, 3'd2, 1, 0, 10'd900));
      vecs.push_back(mk(8'd3,   1, 1, 3'd3, 1, 0, 10'd900));
      vecs.push_back(mk(8'd4,   1, 1, 3'd0, 0, 1, 10'd10));
      vecs.push_back(mk(8'd0,   0, 1, 3'd0, 1, 0, 10'd10));

      for (int i = 0; i < vecs.size(); i++) begin
         prod_in    = vecs[i].prod;
         prod_valid = vecs[i].valid;
         acc_ready  = vecs[i].ready;
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pr, vecs[i].av, vecs[i].out);
      end
      prod_valid = 1'b0;

      // Backpressure: result 36 held while extra products are offered
      acc_ready = 1'b0;
      feed(8'd10); feed(8'd8); feed(8'd9); feed(8'd9);
      chk_all("bp result", 3'd0, 1'b0, 1'b1, 10'd36);
      prod_in    = 8'd50;
      prod_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_all($sformatf("bp hold%0d", i), 3'd0, 1'b0, 1'b1, 10'd36);
      end
      prod_valid = 1'b0;
      acc_ready  = 1'b1;
      step();
      chk_all("bp release", 3'd0, 1'b1, 1'b0, 10'd36);
      feed(8'd1); feed(8'd1); feed(8'd1); feed(8'd1);
      chk_all("bp next group", 3'd0, 1'b0, 1'b1, 10'd4);
      step();

      // Clear after two terms drops them and the product offered with clear
      feed(8'd7); feed(8'd9);
      chk("clr pre term_cnt", 32'(term_cnt), 32'd2);
      clear      = 1'b1;
      prod_in    = 8'd100;
      prod_valid = 1'b1;
      step();
      clear      = 1'b0;
      prod_valid = 1'b0;
      chk("clr term_cnt", 32'(term_cnt), 32'd0);
      chk("clr prod_ready", 32'(prod_ready), 32'd1);
      feed(8'd5); feed(8'd5); feed(8'd5); feed(8'd5);
      chk_all("clr group", 3'd0, 1'b0, 1'b1, 10'd20);
      step();

      // Clear while a result is pending discards it
      acc_ready = 1'b0;
      feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
      chk("clr hold acc_valid pre", 32'(acc_valid), 32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr hold acc_valid", 32'(acc_valid), 32'd0);
      chk("clr hold prod_ready", 32'(prod_ready), 32'd1);

      // Asynchronous reset mid-cycle while holding a result
      feed(8'd2); feed(8'd3); feed(8'd4); feed(8'd5);
      chk_all("rst pre", 3'd0, 1'b0, 1'b1, 10'd14);
      #2 rst_n = 1'b0;
      #1;
      chk_all("rst async", 3'd0, 1'b1, 1'b0, 10'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      acc_ready = 1'b1;
      feed(8'd100); feed(8'd100); feed(8'd100); feed(8'd100);
      chk_all("rst next group", 3'd0, 1'b0, 1'b1, 10'd400);
      step();
      chk("rst final acc_valid", 32'(acc_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
